// File: rtl/time_set_pkg.sv
// Shared types and constants for the alarm-clock time-setting controller.
// REPEAT_DLY / REPEAT_RATE are only used when TIME_SET_AUTOREPEAT_EN is defined.
package time_set_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SET_HR  = 2'd1,
    SET_MIN = 2'd2,
    COMMIT  = 2'd3
  } state_t;

  localparam int HR_MOD_DEF  = 24;
  localparam int MIN_MOD_DEF = 60;

  localparam int REPEAT_DLY  = 500;
  localparam int REPEAT_RATE = 50;

  function automatic logic is_set_state(input state_t s);
    return (s == SET_HR) || (s == SET_MIN);
  endfunction

endpackage

// File: rtl/edge_det.sv
// Registered rising-edge detector; the history register resets high so a
// level already asserted when reset releases is not reported as a press.
module edge_det #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] rise
);

  logic [W-1:0] d_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      d_q <= '1;
    end else begin
      d_q <= d;
    end
  end

  assign rise = d & ~d_q;

endmodule

// File: rtl/time_set_ctrl.sv
// Button-driven hour/minute setting FSM that loads the time registers with a
// one-cycle commit strobe. Define TIME_SET_AUTOREPEAT_EN for held-inc repeat.
module time_set_ctrl
  import time_set_pkg::*;
#(
  parameter int HR_W        = 5,
  parameter int MIN_W       = 6,
  parameter int HR_MOD      = HR_MOD_DEF,
  parameter int MIN_MOD     = MIN_MOD_DEF,
  parameter int TIMEOUT_CYC = 1000,
  parameter int BLINK_CYC   = 250
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             btn_mode,
  input  logic             btn_inc,
  input  logic [HR_W-1:0]  cur_hr,
  input  logic [MIN_W-1:0] cur_min,
  output logic [HR_W-1:0]  set_hr,
  output logic [MIN_W-1:0] set_min,
  output logic             hr_en,
  output logic             min_en,
  output logic             setting,
  output logic             sel_min,
  output logic             blink,
  output state_t           dbg_state
);

  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
  localparam int BL_W = $clog2(BLINK_CYC + 1);

  localparam logic [HR_W-1:0]  HR_LAST  = HR_W'(HR_MOD - 1);
  localparam logic [MIN_W-1:0] MIN_LAST = MIN_W'(MIN_MOD - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYC - 1);
  localparam logic [BL_W-1:0]  BL_LAST  = BL_W'(BLINK_CYC - 1);

  state_t           state;
  state_t           nxt_state;
  logic [HR_W-1:0]  shadow_hr;
  logic [MIN_W-1:0] shadow_min;
  logic [TO_W-1:0]  to_cnt;
  logic [BL_W-1:0]  bl_cnt;

  logic mode_p;
  logic inc_p;
  logic inc_evt;
  logic press_any;
  logic timed_out;
  logic inc_hr;
  logic inc_min;

  edge_det #(.W(1)) u_mode_edge (
    .clk  (clk),
    .rst  (rst),
    .d    (btn_mode),
    .rise (mode_p)
  );

  edge_det #(.W(1)) u_inc_edge (
    .clk  (clk),
    .rst  (rst),
    .d    (btn_inc),
    .rise (inc_p)
  );

`ifdef TIME_SET_AUTOREPEAT_EN
  // rep_cnt equals the number of consecutive held cycles in a set state; after
  // each synthetic press it is rewound so the next one lands REPEAT_RATE later.
  localparam int RP_W = $clog2(REPEAT_DLY + 1);
  localparam logic [RP_W-1:0] RP_FIRE   = RP_W'(REPEAT_DLY);
  localparam logic [RP_W-1:0] RP_RELOAD = RP_W'(REPEAT_DLY - REPEAT_RATE + 1);

  logic [RP_W-1:0] rep_cnt;
  logic            rep_hold;
  logic            rep_fire;

  assign rep_hold = btn_inc && is_set_state(state);
  assign rep_fire = rep_hold && (rep_cnt == RP_FIRE);

  always_ff @(posedge clk) begin
    if (!rst) begin
      rep_cnt <= '0;
    end else if (!rep_hold) begin
      rep_cnt <= '0;
    end else if (rep_fire) begin
      rep_cnt <= RP_RELOAD;
    end else begin
      rep_cnt <= rep_cnt + 1'b1;
    end
  end

  assign inc_evt = inc_p | rep_fire;
`else
  assign inc_evt = inc_p;
`endif

  // Mode has priority: an inc press coinciding with a mode press is dropped.
  assign press_any = mode_p | inc_evt;
  assign timed_out = !press_any && (to_cnt == TO_LAST);
  assign inc_hr    = (state == SET_HR)  && inc_evt && !mode_p;
  assign inc_min   = (state == SET_MIN) && inc_evt && !mode_p;

  always_comb begin
    nxt_state = state;
    case (state)
      IDLE: begin
        if (mode_p) nxt_state = SET_HR;
      end
      SET_HR: begin
        if (mode_p)         nxt_state = SET_MIN;
        else if (timed_out) nxt_state = IDLE;
      end
      SET_MIN: begin
        if (mode_p)         nxt_state = COMMIT;
        else if (timed_out) nxt_state = IDLE;
      end
      COMMIT: begin
        nxt_state = IDLE;
      end
      default: begin
        nxt_state = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      shadow_hr  <= '0;
      shadow_min <= '0;
      to_cnt     <= '0;
      bl_cnt     <= '0;
      blink      <= 1'b0;
      hr_en      <= 1'b0;
      min_en     <= 1'b0;
      setting    <= 1'b0;
      sel_min    <= 1'b0;
    end else begin
      state <= nxt_state;

      if ((state == IDLE) && mode_p) begin
        shadow_hr  <= cur_hr;
        shadow_min <= cur_min;
      end
      // Wrap uses >= so an out-of-range captured value returns to zero.
      if (inc_hr) begin
        shadow_hr <= (shadow_hr >= HR_LAST) ? '0 : shadow_hr + 1'b1;
      end
      if (inc_min) begin
        shadow_min <= (shadow_min >= MIN_LAST) ? '0 : shadow_min + 1'b1;
      end

      if (!is_set_state(nxt_state) || (nxt_state != state) || press_any) begin
        to_cnt <= '0;
      end else begin
        to_cnt <= to_cnt + 1'b1;
      end

      if (!is_set_state(nxt_state)) begin
        blink  <= 1'b0;
        bl_cnt <= '0;
      end else if ((state == IDLE) || inc_hr || inc_min) begin
        blink  <= 1'b1;
        bl_cnt <= '0;
      end else if (bl_cnt == BL_LAST) begin
        blink  <= ~blink;
        bl_cnt <= '0;
      end else begin
        bl_cnt <= bl_cnt + 1'b1;
      end

      hr_en   <= (nxt_state == COMMIT);
      min_en  <= (nxt_state == COMMIT);
      setting <= is_set_state(nxt_state);
      sel_min <= (nxt_state == SET_MIN);
    end
  end

  assign set_hr    = shadow_hr;
  assign set_min   = shadow_min;
  assign dbg_state = state;

endmodule

// File: tb/tb_time_set_ctrl.sv
// Randomized and directed bench for time_set_ctrl against a cycle-level
// behavioural model of the setting sequence.
module tb_time_set_ctrl;
  import time_set_pkg::*;

  localparam int HR_W        = 5;
  localparam int MIN_W       = 6;
  localparam int HR_MOD      = 24;
  localparam int MIN_MOD     = 60;
  localparam int TIMEOUT_CYC = 1000;
  localparam int BLINK_CYC   = 250;

  logic             clk = 1'b0;
  logic             rst;
  logic             btn_mode;
  logic             btn_inc;
  logic [HR_W-1:0]  cur_hr;
  logic [MIN_W-1:0] cur_min;
  logic [HR_W-1:0]  set_hr;
  logic [MIN_W-1:0] set_min;
  logic             hr_en;
  logic             min_en;
  logic             setting;
  logic             sel_min;
  logic             blink;
  state_t           dbg_state;

  // clock / reset block
  always #5 clk = ~clk;

  time_set_ctrl #(
    .HR_W(HR_W), .MIN_W(MIN_W), .HR_MOD(HR_MOD), .MIN_MOD(MIN_MOD),
    .TIMEOUT_CYC(TIMEOUT_CYC), .BLINK_CYC(BLINK_CYC)
  ) dut (
    .clk(clk), .rst(rst), .btn_mode(btn_mode), .btn_inc(btn_inc),
    .cur_hr(cur_hr), .cur_min(cur_min), .set_hr(set_hr), .set_min(set_min),
    .hr_en(hr_en), .min_en(min_en), .setting(setting), .sel_min(sel_min),
    .blink(blink), .dbg_state(dbg_state)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model: phase 0 = not setting, 1 = hours, 2 = minutes, 3 = commit.
  int m_phase, m_hr, m_min, m_quiet, m_t0, m_cyc, m_run;
  bit m_pm, m_pi;

  // Commit observations
  int en_cnt, c_hr, c_min;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_phase = 0; m_hr = 0; m_min = 0; m_quiet = 0; m_t0 = m_cyc; m_run = 0;
    m_pm = 1'b1; m_pi = 1'b1;
  endtask

  task automatic model_step(input bit m, input bit i, input bit r);
    bit mp, ip, syn, in_set;
    m_cyc++;
    if (!r) begin
      model_reset();
      return;
    end
    mp = m && !m_pm;
    ip = i && !m_pi;
    m_pm = m;
    m_pi = i;
    in_set = (m_phase == 1) || (m_phase == 2);
    syn = 1'b0;
`ifdef TIME_SET_AUTOREPEAT_EN
    syn = i && in_set && (m_run >= REPEAT_DLY) && ((m_run - REPEAT_DLY) % REPEAT_RATE == 0);
    m_run = (i && in_set) ? m_run + 1 : 0;
`endif
    case (m_phase)
      0: if (mp) begin
        m_phase = 1; m_hr = cur_hr; m_min = cur_min; m_quiet = 0; m_t0 = m_cyc;
      end
      1, 2: begin
        if (mp) begin
          m_phase = m_phase + 1;
          m_quiet = 0;
        end else if (ip || syn) begin
          if (m_phase == 1) m_hr  = (m_hr  >= HR_MOD - 1)  ? 0 : m_hr + 1;
          else              m_min = (m_min >= MIN_MOD - 1) ? 0 : m_min + 1;
          m_t0 = m_cyc;
          m_quiet = 0;
        end else if (m_quiet == TIMEOUT_CYC - 1) begin
          m_phase = 0;
        end else begin
          m_quiet++;
        end
      end
      default: m_phase = 0;
    endcase
  endtask

  function automatic logic [31:0] model_outs();
    bit en, st, sm, bl;
    en = (m_phase == 3);
    st = (m_phase == 1) || (m_phase == 2);
    sm = (m_phase == 2);
    bl = st && ((((m_cyc - m_t0) / BLINK_CYC) % 2) == 0);
    return {16'b0, en, en, st, sm, bl, HR_W'(m_hr), MIN_W'(m_min)};
  endfunction

  // driver: one clock with the given levels, then compare every output
  task automatic tick(input bit m, input bit i, input bit r);
    btn_mode = m;
    btn_inc  = i;
    rst      = r;
    @(posedge clk);
    model_step(m, i, r);
    #1;
    check("outs", {16'b0, hr_en, min_en, setting, sel_min, blink, set_hr, set_min}, model_outs());
    if (hr_en) begin
      en_cnt++;
      c_hr  = int'(set_hr);
      c_min = int'(set_min);
    end
  endtask

  task automatic press_mode();
    tick(1'b1, 1'b0, 1'b1);
    tick(1'b0, 1'b0, 1'b1);
  endtask

  task automatic press_inc();
    tick(1'b0, 1'b1, 1'b1);
    tick(1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    int exp_rep;
    m_cyc = 0;
    model_reset();
    en_cnt = 0; c_hr = -1; c_min = -1;
    rst = 1'b0; btn_mode = 1'b0; btn_inc = 1'b0;
    cur_hr = 5'd3; cur_min = 6'd14;

    // Reset with mode held high, then release: no press seen
    repeat (3) tick(1'b1, 1'b0, 1'b0);
    check("reset_outs", {27'b0, hr_en, min_en, setting, sel_min, blink}, 32'd0);
    check("reset_shadow", {21'b0, set_hr, set_min}, 32'd0);
    repeat (3) tick(1'b1, 1'b0, 1'b1);
    check("held_mode_state", dbg_state, IDLE);
    check("held_mode_setting", setting, 1'b0);
    tick(1'b0, 1'b0, 1'b1);

    // 07:45 -> 10:47
    cur_hr = 5'd7; cur_min = 6'd45; en_cnt = 0;
    press_mode();
    repeat (3) press_inc();
    press_mode();
    repeat (2) press_inc();
    press_mode();
    repeat (2) tick(1'b0, 1'b0, 1'b1);
    check("commit1_pulses", en_cnt, 1);
    check("commit1_hr", c_hr, 10);
    check("commit1_min", c_min, 47);

    // 23:59 -> 00:00, both wraps
    cur_hr = 5'd23; cur_min = 6'd59; en_cnt = 0;
    press_mode(); press_inc(); press_mode(); press_inc(); press_mode();
    repeat (2) tick(1'b0, 1'b0, 1'b1);
    check("commit2_pulses", en_cnt, 1);
    check("commit2_hr", c_hr, 0);
    check("commit2_min", c_min, 0);

    // Timeout from SET_MIN
    cur_hr = 5'd1; cur_min = 6'd2; en_cnt = 0;
    press_mode(); press_mode();
    check("tmo_in_min", sel_min, 1'b1);
    repeat (TIMEOUT_CYC) tick(1'b0, 1'b0, 1'b1);
    check("tmo_state", dbg_state, IDLE);
    check("tmo_setting", setting, 1'b0);
    check("tmo_pulses", en_cnt, 0);

    // Simultaneous mode+inc in SET_HR
    cur_hr = 5'd5; cur_min = 6'd20;
    press_mode();
    tick(1'b1, 1'b1, 1'b1);
    tick(1'b0, 1'b0, 1'b1);
    check("simul_sel_min", sel_min, 1'b1);
    check("simul_hr", set_hr, 5'd5);
    press_mode();
    repeat (2) tick(1'b0, 1'b0, 1'b1);

    // Reset during COMMIT
    cur_hr = 5'd12; cur_min = 6'd34; en_cnt = 0;
    press_mode(); press_mode();
    tick(1'b1, 1'b0, 1'b1);
    check("pre_rst_commit", hr_en, 1'b1);
    tick(1'b0, 1'b0, 1'b0);
    check("rst_commit_en", {hr_en, min_en}, 2'b00);
    check("rst_commit_state", dbg_state, IDLE);
    repeat (3) tick(1'b0, 1'b0, 1'b1);
    check("rst_commit_pulses", en_cnt, 1);
    check("rst_commit_shadow", {21'b0, set_hr, set_min}, 32'd0);

    // Held inc for 600 cycles in SET_MIN starting from 00
`ifdef TIME_SET_AUTOREPEAT_EN
    exp_rep = 3;
`else
    exp_rep = 1;
`endif
    cur_hr = 5'd9; cur_min = 6'd0;
    press_mode(); press_mode();
    repeat (600) tick(1'b0, 1'b1, 1'b1);
    tick(1'b0, 1'b0, 1'b1);
    check("hold_inc_min", set_min, 6'(exp_rep));
    tick(1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b1);

    // Randomized traffic, including out-of-range current time and resets
    for (int n = 0; n < 700; n++) begin
      int k;
      int dur;
      bit m, i;
      k = $urandom_range(0, 99);
      if (k < 2) begin
        repeat (2) tick(1'b0, 1'b0, 1'b0);
      end else if (k < 4) begin
        repeat (TIMEOUT_CYC + 5) tick(1'b0, 1'b0, 1'b1);
      end else if (k < 14) begin
        cur_hr  = HR_W'($urandom_range(0, 31));
        cur_min = MIN_W'($urandom_range(0, 63));
      end else begin
        m = ($urandom_range(0, 3) == 0);
        i = 1'($urandom_range(0, 1));
        dur = $urandom_range(1, 4);
        repeat (dur) tick(m, i, 1'b1);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
